// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing the register file's single write port.
// Optional `RFWB_ZERO_GUARD_EN: accepted writes to register 0 are handshaked but never enabled.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 6,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               rf_we,
    output logic [AW-1:0]      rf_wa,
    output logic [DW-1:0]      rf_wd,
    output logic [NREQ-1:0]    last_grant
);

    localparam int PW = $clog2(NREQ);

    // Handshake: requester i is accepted in a cycle when req_valid[i] & req_ready[i].
    // A requester holds valid/addr/data until accepted; ready may drop before that.

    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_wa_q, rf_wa_d;
    logic [DW-1:0]   rf_wd_q, rf_wd_d;
    logic [NREQ-1:0] last_grant_q, last_grant_d;

    logic [AW-1:0]   addr_arr [NREQ];
    logic [DW-1:0]   data_arr [NREQ];

    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic [NREQ-1:0] grant_oh;
    logic [PW-1:0]   scan_idx;
    logic            accept;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        s = s % NREQ;
        return s[PW-1:0];
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*AW +: AW];
        assign data_arr[i] = req_data[i*DW +: DW];
    end

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = wrap_add(rr_ptr_q, k);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        if (grant_found) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant_idx == PW'(k)) begin
                sel_addr = addr_arr[k];
                sel_data = data_arr[k];
            end
        end
    end

    assign req_ready = (rst || freeze) ? '0 : grant_oh;
    assign accept    = grant_found && !rst && !freeze;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        rf_we_d      = 1'b0;
        rf_wa_d      = rf_wa_q;
        rf_wd_d      = rf_wd_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rr_ptr_d     = wrap_add(grant_idx, 1);
            rf_wa_d      = sel_addr;
            rf_wd_d      = sel_data;
            last_grant_d = grant_oh;
`ifdef RFWB_ZERO_GUARD_EN
            // Register 0 is hard-wired zero: complete the handshake, suppress the write.
            rf_we_d      = (sel_addr != '0);
`else
            rf_we_d      = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            rf_we_q      <= 1'b0;
            rf_wa_q      <= '0;
            rf_wd_q      <= '0;
            last_grant_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            rf_we_q      <= rf_we_d;
            rf_wa_q      <= rf_wa_d;
            rf_wd_q      <= rf_wd_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_wa      = rf_wa_q;
    assign rf_wd      = rf_wd_q;
    assign last_grant = last_grant_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 6;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               freeze;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               rf_we;
    logic [AW-1:0]      rf_wa;
    logic [DW-1:0]      rf_wd;
    logic [NREQ-1:0]    last_grant;

    regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd),
        .last_grant (last_grant)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int              m_ptr = 0;
    logic            m_we;
    logic [AW-1:0]   m_wa;
    logic [DW-1:0]   m_wd;
    logic [NREQ-1:0] m_lg;
    logic [AW+DW-1:0] exp_q[$];

    // Register file fed by the DUT's write port
    logic [DW-1:0] dut_rf [64];
    always @(negedge clk) begin
        if (rf_we === 1'b1) dut_rf[rf_wa] <= rf_wd;
    end

    function automatic logic [NREQ-1:0] model_ready();
        logic [NREQ-1:0] r;
        int i;
        r = '0;
        if (rst !== 1'b1 && freeze !== 1'b1) begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (r == '0 && req_valid[i]) r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    // Advance one clock edge and update the model with the inputs seen at that edge.
    task automatic tick(output int acc);
        logic [NREQ-1:0] r;
        @(posedge clk);
        r = model_ready();
        acc = -1;
        if (rst) begin
            m_ptr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_lg = '0;
        end else begin
            m_we = 1'b0;
            for (int k = 0; k < NREQ; k++) if (r[k]) acc = k;
            if (acc >= 0) begin
                m_ptr = (acc + 1) % NREQ;
                m_lg  = r;
                m_wa  = req_addr[acc*AW +: AW];
                m_wd  = req_data[acc*DW +: DW];
`ifdef RFWB_ZERO_GUARD_EN
                m_we  = (m_wa != '0);
`else
                m_we  = 1'b1;
`endif
                if (m_we) exp_q.push_back({m_wa, m_wd});
            end
        end
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        int acc;
        req_valid = '0;
        freeze    = 1'b0;
        rst       = 1'b1;
        tick(acc);
        tick(acc);
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        int acc;
        rst = 1'b1; freeze = 1'b0; req_valid = '1;
        set_req(0, 6'd1, 32'h11); set_req(1, 6'd2, 32'h22); set_req(2, 6'd3, 32'h33);
        tick(acc);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b expected 000", req_ready); end
            n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", rf_we); end
            n_checks++; if (rf_wa !== 6'd0) begin n_fail++; $display("FAIL reset_wa: got %0d expected 0", rf_wa); end
            n_checks++; if (rf_wd !== 32'd0) begin n_fail++; $display("FAIL reset_wd: got %h expected 0", rf_wd); end
            n_checks++; if (last_grant !== 3'b000) begin n_fail++; $display("FAIL reset_last_grant: got %b expected 000", last_grant); end
            tick(acc);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 001", req_ready); end
        tick(acc);
        req_valid = '0;
    endtask

    task automatic test_single();
        int acc;
        do_reset();
        req_valid = 3'b010;
        set_req(1, 6'd5, 32'hDEADBEEF);
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready: got %b expected 010", req_ready); end
        tick(acc);
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b expected 1", rf_we); end
        n_checks++; if (rf_wa !== 6'd5) begin n_fail++; $display("FAIL single_wa: got %0d expected 5", rf_wa); end
        n_checks++; if (rf_wd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_wd: got %h expected deadbeef", rf_wd); end
        n_checks++; if (last_grant !== 3'b010) begin n_fail++; $display("FAIL single_last_grant: got %b expected 010", last_grant); end
        tick(acc);
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL single_we_idle: got %b expected 0", rf_we); end
    endtask

    task automatic test_round_robin();
        int acc;
        logic [AW-1:0] a;
        do_reset();
        req_valid = 3'b111;
        set_req(0, 6'd10, 32'hA0); set_req(1, 6'd11, 32'hA1); set_req(2, 6'd12, 32'hA2);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 3'(1 << (c % 3))) begin
                n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %0d", c, req_ready, c % 3);
            end
            if (c > 0) begin
                a = 6'(10 + (c - 1) % 3);
                n_checks++;
                if (rf_we !== 1'b1 || rf_wa !== a) begin
                    n_fail++; $display("FAIL rr_wa[%0d]: got we=%b wa=%0d expected we=1 wa=%0d", c, rf_we, rf_wa, a);
                end
            end
            tick(acc);
        end
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rf_wa !== 6'd12 || last_grant !== 3'b100) begin
            n_fail++; $display("FAIL rr_last: got wa=%0d lg=%b expected wa=12 lg=100", rf_wa, last_grant);
        end
    endtask

    task automatic test_freeze();
        int acc;
        do_reset();
        req_valid = 3'b111;
        set_req(0, 6'd20, 32'hB0); set_req(1, 6'd21, 32'hB1); set_req(2, 6'd22, 32'hB2);
        tick(acc);
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL frz_pre_grant: got %b expected 010", req_ready); end
        tick(acc);
        freeze = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL frz_ready[%0d]: got %b expected 000", c, req_ready); end
            if (c == 1) begin
                n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL frz_we[%0d]: got %b expected 0", c, rf_we); end
            end
            tick(acc);
        end
        freeze = 1'b0;
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL frz_we_after: got %b expected 0", rf_we); end
        n_checks++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL frz_resume_grant: got %b expected 100", req_ready); end
        tick(acc);
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rf_we !== 1'b1 || rf_wa !== 6'd22) begin
            n_fail++; $display("FAIL frz_resume_write: got we=%b wa=%0d expected we=1 wa=22", rf_we, rf_wa);
        end
    endtask

    task automatic test_same_addr();
        int acc;
        do_reset();
        req_valid = 3'b011;
        set_req(0, 6'd9, 32'h1); set_req(1, 6'd9, 32'h2);
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL same_first_grant: got %b expected 001", req_ready); end
        tick(acc);
        req_valid = 3'b010;
        @(negedge clk);
        n_checks++; if (rf_wa !== 6'd9 || rf_wd !== 32'h1) begin
            n_fail++; $display("FAIL same_wd1: got wa=%0d wd=%h expected wa=9 wd=1", rf_wa, rf_wd);
        end
        tick(acc);
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (rf_wa !== 6'd9 || rf_wd !== 32'h2) begin
            n_fail++; $display("FAIL same_wd2: got wa=%0d wd=%h expected wa=9 wd=2", rf_wa, rf_wd);
        end
        tick(acc);
        @(negedge clk);
        n_checks++; if (dut_rf[9] !== 32'h2) begin n_fail++; $display("FAIL same_rf9: got %h expected 2", dut_rf[9]); end
    endtask

    task automatic test_zero_guard();
        int acc;
        do_reset();
        req_valid = 3'b001;
        set_req(0, 6'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL zero_ready: got %b expected 001", req_ready); end
        tick(acc);
        req_valid = '0;
        @(negedge clk);
        n_checks++; if (last_grant !== 3'b001) begin n_fail++; $display("FAIL zero_last_grant: got %b expected 001", last_grant); end
`ifdef RFWB_ZERO_GUARD_EN
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL zero_we: got %b expected 0", rf_we); end
`else
        n_checks++; if (rf_we !== 1'b1 || rf_wa !== 6'd0 || rf_wd !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL zero_write: got we=%b wa=%0d wd=%h expected we=1 wa=0 wd=ffffffff", rf_we, rf_wa, rf_wd);
        end
`endif
        tick(acc);
    endtask

    task automatic test_random();
        int acc;
        logic [NREQ-1:0] pending;
        logic [AW+DW-1:0] e;
        do_reset();
        exp_q.delete();
        pending = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pending[i] && $urandom_range(0, 9) < 6) begin
                    pending[i] = 1'b1;
                    set_req(i, 6'($urandom_range(0, 63)), $urandom);
                end
            end
            req_valid = pending;
            freeze    = ($urandom_range(0, 9) == 0);
            rst       = ($urandom_range(0, 49) == 0);
            @(negedge clk);
            n_checks++; if (req_ready !== model_ready()) begin
                n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, model_ready());
            end
            n_checks++; if (rf_we !== m_we || rf_wa !== m_wa || rf_wd !== m_wd || last_grant !== m_lg) begin
                n_fail++; $display("FAIL rand_out[%0d]: got we=%b wa=%0d wd=%h lg=%b expected we=%b wa=%0d wd=%h lg=%b",
                                   c, rf_we, rf_wa, rf_wd, last_grant, m_we, m_wa, m_wd, m_lg);
            end
            if (rf_we === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                n_checks++; if ({rf_wa, rf_wd} !== e) begin
                    n_fail++; $display("FAIL rand_sb[%0d]: got wa=%0d wd=%h expected wa=%0d wd=%h", c, rf_wa, rf_wd, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
            tick(acc);
            if (acc >= 0) pending[acc] = 1'b0;
        end
        req_valid = '0; freeze = 1'b0; rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                n_checks++; if ({rf_wa, rf_wd} !== e) begin
                    n_fail++; $display("FAIL rand_drain: got wa=%0d wd=%h expected wa=%0d wd=%h", rf_wa, rf_wd, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
            tick(acc);
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_leftover: got %0d pending writes expected 0", exp_q.size()); end
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_freeze();
        test_same_addr();
        test_zero_guard();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 64×32 register file. It shares the register file's single write port among NREQ write-back sources (e.g. ALU, load unit, multiplier) using round-robin arbitration with a valid/ready handshake. The winning write is registered and presented to the register file's write port one cycle after acceptance. The block sits between the execute/memory stages and the register file write port.

## Interface
Parameters:
- NREQ, 3 — number of write-back requesters; legal range 2..4.
- AW, 6 — register address width (64 registers).
- DW, 32 — write data width.

Ports:
- clk  in  1  — single clock; all state updates on posedge.
- rst  in  1  — synchronous reset, active-high.
- freeze  in  1  — when 1, no request is accepted (all ready low); the output stage drains normally.
- req_valid  in  NREQ  — request i valid.
- req_addr  in  NREQ*AW  — packed destination addresses; requester i occupies bits [i*AW +: AW].
- req_data  in  NREQ*DW  — packed write data; requester i occupies bits [i*DW +: DW].
- req_ready  out  NREQ  — one-hot or zero; asserted for the granted requester.
- rf_we  out  1  — write enable to the register file.
- rf_wa  out  AW  — write address to the register file.
- rf_wd  out  DW  — write data to the register file.
- last_grant  out  NREQ  — one-hot index of the most recently accepted requester.

## Operation
- Grant logic is combinational.
  - Search order starts at rr_ptr and wraps modulo NREQ.
  - The first i with req_valid[i]=1 is granted.
  - req_ready[i]=1 only for that i, and only when rst=0 and freeze=0.
- Handshake: a request is accepted when req_valid[i]&req_ready[i]=1 in a cycle. At most one request is accepted per cycle.
- Requesters must hold valid, addr and data stable until accepted. Ready may be withdrawn before acceptance.
- On acceptance of requester g:
  - rr_ptr <= (g+1) mod NREQ.
  - rf_we <= 1, rf_wa <= addr[g], rf_wd <= data[g].
  - last_grant <= onehot(g).
- No acceptance in a cycle: rf_we <= 0; rf_wa, rf_wd, rr_ptr and last_grant hold.
- State: rr_ptr (ceil(log2 NREQ) bits) plus the registered output stage. No internal FSM beyond the round-robin pointer.
- Same-address requests from two sources are serialized in grant order. The later write wins in the register file.
- Address/data widths pass through unmodified; there is no arithmetic on data.

## Timing
- Reset values: rf_we=0, rf_wa=0, rf_wd=0, last_grant=0, rr_ptr=0.
- During reset: req_ready=0 (combinational mask).
- Reset mid-operation: the write accepted in the cycle before rst rises still appears on rf_we in the rst cycle only if it was registered before that edge. Writes are not accepted while rst=1. The first cycle after reset deassertion grants from index 0.
- Latency: accept in cycle N → rf_we=1 in cycle N+1. The register file commits at the end of N+1, so the value is readable in N+2.
- Throughput: one write per cycle, sustained.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once every NREQ cycles.
- freeze asserted in cycle N:
  - No acceptance in N.
  - rf_we in N+1 is 0.
  - rr_ptr holds.
- freeze and rst together: rst dominates.

## Configuration
- Macro RFWB_ZERO_GUARD_EN.
- Defined:
  - Accepted requests with address 0 are handshaked normally: ready=1, rr_ptr and last_grant update.
  - rf_we stays 0 for that cycle, so register 0 remains constant zero.
- Undefined:
  - Address 0 is an ordinary writable register.

## Test plan
- Reset: hold rst=1 for 2 cycles with all req_valid=1.
  - Required: req_ready=0, rf_we=0, rf_wa=0, rf_wd=0, last_grant=0.
  - First cycle after release: req_ready=3'b001.
- Single requester: req_valid=3'b010, addr=5, data=32'hDEADBEEF.
  - Required: ready=3'b010 same cycle; next cycle rf_we=1, rf_wa=5, rf_wd=32'hDEADBEEF, last_grant=3'b010.
- Round-robin: all three valid continuously for 6 cycles from reset.
  - Required: grant sequence 0,1,2,0,1,2; rf_wa follows each requester's address, one cycle delayed.
- Freeze: all valid, freeze=1 for 2 cycles mid-stream after a grant to 1.
  - Required: req_ready=0; rf_we=0 the cycles after.
  - On release the next grant is 2.
- Same-address serialization: req 0 writes addr 9 / 32'h1, req 1 writes addr 9 / 32'h2, both valid with rr_ptr=0.
  - Required: rf_wd sequence 32'h1 then 32'h2; a model register file reads 32'h2 at addr 9.
- Zero guard (with RFWB_ZERO_GUARD_EN): req 0 writes addr 0 / 32'hFFFF_FFFF.
  - Required: ready=1, last_grant=3'b001, rf_we stays 0.
  - Without the macro: rf_we=1, rf_wa=0.
